trig_pulse_shaper: RTL and testbench

TRIG_PULSE_SHAPER -- requirements
Module: trig_pulse_shaper

---
 rtl/trig_pulse_shaper.sv | 166 ++++++++++++++++
 tb/tb_trig_pulse_shaper.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/trig_pulse_shaper.sv
// Two independent trigger channels: rising-edge detect, programmable delay,
// fixed-width output pulse and hold-off dead time, each with a saturating issue counter.
module trig_pulse_shaper #(
    parameter int TMR   = 0,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LCT_IN,
    input  logic             GTRG_IN,
    input  logic             ENA,
    input  logic [3:0]       LCT_DLY,
    input  logic [3:0]       GTRG_DLY,
    input  logic [2:0]       PW,
    input  logic [3:0]       HOLDOFF,
    input  logic             CNT_CLR,
    output logic             LCT_OUT,
    output logic             GTRG_OUT,
    output logic [CNT_W-1:0] LCT_CNT,
    output logic [CNT_W-1:0] GTRG_CNT,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLD} state_t;

    localparam int NCOPY = (TMR != 0) ? 3 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       trig_in;
    logic [3:0]       dly_in [2];
    logic [1:0]       pulse_out;
    logic [1:0]       busy_ch;
    logic [CNT_W-1:0] cnt_out [2];
    logic [2:0]       pw_sel;

    assign trig_in   = {GTRG_IN, LCT_IN};
    assign dly_in[0] = LCT_DLY;
    assign dly_in[1] = GTRG_DLY;
    assign pw_sel    = (PW == 3'd0) ? 3'd1 : PW;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            state_t           state_reg, state_next;
            logic             in_q_reg;
            logic [3:0]       tmr_reg, tmr_next;
            logic [2:0]       pw_lat_reg, pw_lat_next;
            logic [3:0]       hold_lat_reg, hold_lat_next;
            logic             out_reg;
            logic             edge_det;
            logic             enter_pulse;
            logic [CNT_W-1:0] cnt_copy_reg [NCOPY];
            logic [CNT_W-1:0] cnt_voted;
            logic [CNT_W-1:0] cnt_next;

            assign edge_det = trig_in[gi] & ~in_q_reg;

            // One shared down-counter times the delay, pulse and hold-off phases.
            always_comb begin
                state_next    = state_reg;
                tmr_next      = tmr_reg;
                pw_lat_next   = pw_lat_reg;
                hold_lat_next = hold_lat_reg;
                enter_pulse   = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (edge_det && ENA) begin
                            pw_lat_next   = pw_sel;
                            hold_lat_next = HOLDOFF;
                            if (dly_in[gi] == 4'd0) begin
                                state_next  = PULSE;
                                enter_pulse = 1'b1;
                                tmr_next    = {1'b0, pw_sel - 3'd1};
                            end else begin
                                state_next = DELAY;
                                tmr_next   = dly_in[gi] - 4'd1;
                            end
                        end
                    end
                    DELAY: begin
                        if (tmr_reg == 4'd0) begin
                            state_next  = PULSE;
                            enter_pulse = 1'b1;
                            tmr_next    = {1'b0, pw_lat_reg - 3'd1};
                        end else begin
                            tmr_next = tmr_reg - 4'd1;
                        end
                    end
                    PULSE: begin
                        if (tmr_reg == 4'd0) begin
                            if (hold_lat_reg != 4'd0) begin
                                state_next = HOLD;
                                tmr_next   = hold_lat_reg - 4'd1;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            tmr_next = tmr_reg - 4'd1;
                        end
                    end
                    HOLD: begin
                        if (tmr_reg == 4'd0) begin
                            state_next = IDLE;
                        end else begin
                            tmr_next = tmr_reg - 4'd1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            if (NCOPY == 3) begin : g_vote
                assign cnt_voted = (cnt_copy_reg[0] & cnt_copy_reg[1]) |
                                   (cnt_copy_reg[1] & cnt_copy_reg[2]) |
                                   (cnt_copy_reg[0] & cnt_copy_reg[2]);
            end else begin : g_single
                assign cnt_voted = cnt_copy_reg[0];
            end

            // Clear has priority over a coincident increment.
            always_comb begin
                cnt_next = cnt_voted;
                if (CNT_CLR) begin
                    cnt_next = '0;
                end else if (enter_pulse && (cnt_voted != CNT_MAX)) begin
                    cnt_next = cnt_voted + CNT_W'(1);
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_reg    <= IDLE;
                    in_q_reg     <= 1'b1;
                    tmr_reg      <= 4'd0;
                    pw_lat_reg   <= 3'd0;
                    hold_lat_reg <= 4'd0;
                    out_reg      <= 1'b0;
                    for (int i = 0; i < NCOPY; i++) begin
                        cnt_copy_reg[i] <= '0;
                    end
                end else begin
                    state_reg    <= state_next;
                    in_q_reg     <= trig_in[gi];
                    tmr_reg      <= tmr_next;
                    pw_lat_reg   <= pw_lat_next;
                    hold_lat_reg <= hold_lat_next;
                    out_reg      <= (state_next == PULSE);
                    for (int i = 0; i < NCOPY; i++) begin
                        cnt_copy_reg[i] <= cnt_next;
                    end
                end
            end

            assign pulse_out[gi] = out_reg;
            assign busy_ch[gi]   = (state_reg != IDLE);
            assign cnt_out[gi]   = cnt_voted;
        end
    endgenerate

    assign LCT_OUT  = pulse_out[0];
    assign GTRG_OUT = pulse_out[1];
    assign LCT_CNT  = cnt_out[0];
    assign GTRG_CNT = cnt_out[1];
    assign BUSY     = |busy_ch;

endmodule

// File: tb/tb_trig_pulse_shaper.sv
// Directed bench for trig_pulse_shaper: latency, width, hold-off, saturation,
// clear priority, enable gating and asynchronous reset behaviour.
module tb_trig_pulse_shaper;

    logic       CLK = 1'b0;
    logic       RST;
    logic       LCT_IN, GTRG_IN, ENA, CNT_CLR;
    logic [3:0] LCT_DLY, GTRG_DLY, HOLDOFF;
    logic [2:0] PW;
    logic       LCT_OUT, GTRG_OUT, BUSY;
    logic [3:0] LCT_CNT, GTRG_CNT;

    int tests_run    = 0;
    int tests_failed = 0;

    trig_pulse_shaper #(.TMR(0), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .LCT_IN(LCT_IN), .GTRG_IN(GTRG_IN), .ENA(ENA),
        .LCT_DLY(LCT_DLY), .GTRG_DLY(GTRG_DLY), .PW(PW), .HOLDOFF(HOLDOFF),
        .CNT_CLR(CNT_CLR), .LCT_OUT(LCT_OUT), .GTRG_OUT(GTRG_OUT),
        .LCT_CNT(LCT_CNT), .GTRG_CNT(GTRG_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [12:0] gin_pat;
        int          hi_cnt;

        RST = 1'b1; LCT_IN = 1'b0; GTRG_IN = 1'b0; ENA = 1'b0; CNT_CLR = 1'b0;
        LCT_DLY = 4'd0; GTRG_DLY = 4'd0; PW = 3'd0; HOLDOFF = 4'd0;
        tick(); tick();
        check("rst_lct_out", LCT_OUT, 0);
        check("rst_gtrg_out", GTRG_OUT, 0);
        check("rst_lct_cnt", LCT_CNT, 0);
        check("rst_gtrg_cnt", GTRG_CNT, 0);
        check("rst_busy", BUSY, 0);
        RST = 1'b0;
        tick(); tick();

        // Single rise, no delay, width 3
        ENA = 1'b1; PW = 3'd3;
        LCT_IN = 1'b1; tick();
        check("a_out_k", LCT_OUT, 1);
        check("a_busy_k", BUSY, 1);
        LCT_IN = 1'b0; tick();
        check("a_out_k1", LCT_OUT, 1);
        tick();
        check("a_out_k2", LCT_OUT, 1);
        tick();
        check("a_out_k3", LCT_OUT, 0);
        check("a_busy_k3", BUSY, 0);
        check("a_cnt", LCT_CNT, 1);

        // GTRG delay 5, PW 0 -> 1 cycle, hold-off 4; second rise and HOLD-exit rise dropped
        GTRG_DLY = 4'd5; PW = 3'd0; HOLDOFF = 4'd4;
        gin_pat = 13'b1_1100_0000_1001;
        for (int c = 0; c < 13; c++) begin
            GTRG_IN = gin_pat[c];
            tick();
            check($sformatf("b_gout_c%0d", c), GTRG_OUT, (c == 5) ? 1 : 0);
            check($sformatf("b_busy_c%0d", c), BUSY, (c < 10) ? 1 : 0);
        end
        GTRG_IN = 1'b0; tick();
        check("b_gcnt", GTRG_CNT, 1);
        check("b_lcnt", LCT_CNT, 1);
        GTRG_DLY = 4'd0; HOLDOFF = 4'd0;

        // Input held high 20 cycles -> one pulse of width 2
        PW = 3'd2; hi_cnt = 0;
        LCT_IN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (LCT_OUT) hi_cnt++;
        end
        check("c_held_hi_cycles", hi_cnt, 2);
        check("c_held_cnt", LCT_CNT, 2);
        LCT_IN = 1'b0; tick();

        // PW changed mid-DELAY keeps the latched width
        LCT_DLY = 4'd3; hi_cnt = 0;
        LCT_IN = 1'b1; tick();
        LCT_IN = 1'b0; PW = 3'd7;
        for (int c = 1; c < 10; c++) begin
            tick();
            if (LCT_OUT) hi_cnt++;
            if (c == 3) check("c_dly_out_k3", LCT_OUT, 1);
            if (c == 2) check("c_dly_out_k2", LCT_OUT, 0);
        end
        check("c_dly_hi_cycles", hi_cnt, 2);
        check("c_dly_cnt", LCT_CNT, 3);

        // ENA low blocks a rise in IDLE
        ENA = 1'b0; LCT_DLY = 4'd0; PW = 3'd1;
        LCT_IN = 1'b1; tick();
        check("d_ena0_out", LCT_OUT, 0);
        check("d_ena0_busy", BUSY, 0);
        LCT_IN = 1'b0; tick();
        // ENA dropped during DELAY: pulse still issues
        ENA = 1'b1; LCT_DLY = 4'd2;
        LCT_IN = 1'b1; tick();
        check("d_dly_busy", BUSY, 1);
        ENA = 1'b0; LCT_IN = 1'b0; tick();
        check("d_dly_out_k1", LCT_OUT, 0);
        tick();
        check("d_dly_out_k2", LCT_OUT, 1);
        tick();
        check("d_dly_out_k3", LCT_OUT, 0);
        check("d_dly_cnt", LCT_CNT, 4);
        ENA = 1'b1; LCT_DLY = 4'd0;

        // Asynchronous reset mid-PULSE, input held high across release
        PW = 3'd4;
        LCT_IN = 1'b1; tick();
        check("e_pre_out", LCT_OUT, 1);
        #2 RST = 1'b1;
        #1;
        check("e_async_out", LCT_OUT, 0);
        check("e_async_cnt", LCT_CNT, 0);
        check("e_async_busy", BUSY, 0);
        tick(); tick();
        RST = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (LCT_OUT) hi_cnt++;
        end
        check("e_held_no_pulse", hi_cnt, 0);
        check("e_held_cnt", LCT_CNT, 0);
        LCT_IN = 1'b0; tick();
        LCT_IN = 1'b1; tick();
        check("e_rearm_out", LCT_OUT, 1);
        LCT_IN = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("e_rearm_cnt", LCT_CNT, 1);

        // Saturation at 15 with CNT_W=4
        PW = 3'd1;
        CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
        check("f_clr", LCT_CNT, 0);
        for (int p = 1; p <= 20; p++) begin
            LCT_IN = 1'b1; tick();
            check($sformatf("f_sat_p%0d", p), LCT_CNT, (p > 15) ? 15 : p);
            LCT_IN = 1'b0; tick();
        end
        // Clear coincident with an increment wins
        CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
        for (int p = 0; p < 3; p++) begin
            LCT_IN = 1'b1; tick();
            LCT_IN = 1'b0; tick();
        end
        check("f_pre_clr_cnt", LCT_CNT, 3);
        LCT_IN = 1'b1; CNT_CLR = 1'b1; tick();
        CNT_CLR = 1'b0;
        check("f_clr_wins_cnt", LCT_CNT, 0);
        check("f_clr_wins_out", LCT_OUT, 1);
        LCT_IN = 1'b0; tick(); tick();

        // Simultaneous edges on both channels
        CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
        LCT_IN = 1'b1; GTRG_IN = 1'b1; tick();
        check("g_both_lout", LCT_OUT, 1);
        check("g_both_gout", GTRG_OUT, 1);
        LCT_IN = 1'b0; GTRG_IN = 1'b0; tick();
        check("g_both_lcnt", LCT_CNT, 1);
        check("g_both_gcnt", GTRG_CNT, 1);
        check("g_both_idle", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
